acc_out_serializer: RTL and testbench
=====================================

// Module: acc_out_serializer
// PURPOSE
//  Downstream of the systolic array's accumulators. Captures one column of R
//  signed WY-bit accumulator results (one per row) in a single handshake.
//  Requantizes each to WO bits: arithmetic shift right with round-half-up,
//  then signed saturation. Streams the results one lane per beat onto an
//  AXI-Stream master port, with full backpressure.
// PARAMETERS
//  R      4   lanes (rows) per captured vector
//  WY     16  accumulator width, signed
//  WO     8   output element width, signed; WO <= WY
//  SHIFT  4   right-shift amount; 0 = pass-through then saturate; SHIFT < WY
// PORTS
//  clk       in   1      clock, all logic on posedge
//  rst       in   1      synchronous reset, active-high
//  s_valid   in   1      input vector valid
//  s_ready   out  1      block can accept a vector
//  s_data    in   R*WY   lane r at bits [r*WY +: WY], signed
//  s_last    in   1      vector is the final one of a tile
//  m_valid   out  1      output beat valid
//  m_ready   in   1      downstream accepts beat
//  m_data    out  WO     requantized lane, signed
//  m_last    out  1      final beat of a tile
// BEHAVIOUR
//  - Reset (rst=1 at posedge): m_valid=0, m_data=0, m_last=0, s_ready=1.
//    Lane counter=0, state=IDLE. Any captured or in-flight vector is dropped.
//  - Two-state FSM:
//    - IDLE: s_ready=1, m_valid=0.
//    - SEND: m_valid=1.
//    - Transitions:
//      - IDLE -> SEND on an s_valid&s_ready capture.
//      - SEND -> IDLE when the last lane (cnt==R-1) is taken and no new
//        capture occurs in that cycle.
//  - Capture: on the s_valid&s_ready edge, latch s_data and s_last and set
//    cnt=0. First beat is valid the next cycle (latency 1).
//  - s_ready=1 in IDLE, and also in SEND when cnt==R-1 && m_ready.
//    - Second case is a back-to-back capture: cnt returns to 0 and the state
//      stays SEND with no bubble.
//    - s_ready depends combinationally on m_ready only in that case.
//  - Beat: on m_valid&m_ready, cnt increments; it wraps R-1 -> 0 only via a
//    capture or the return to IDLE.
//    - m_data and m_last hold stable while m_valid&!m_ready.
//  - Lane order: lane 0 first, lane R-1 last.
//    - m_last = captured s_last && cnt==R-1; 0 on all other beats.
//  - Arithmetic, per lane x (signed WY):
//    - t = sext(x, WY+1) + (SHIFT>0 ? 2**(SHIFT-1) : 0), computed in WY+1
//      bits so no overflow is possible.
//    - q = t >>> SHIFT (arithmetic shift, floor).
//    - m_data = q > 2**(WO-1)-1 ? 2**(WO-1)-1 : q < -2**(WO-1) ? -2**(WO-1) : q.
//  - Requantization is a registered or combinational function of the
//    selected lane. m_data must be valid in the same cycle as m_valid.
//  - Sustained throughput is 1 beat/cycle with m_ready=1, i.e. R cycles per
//    vector with no idle cycles between vectors.
//  - s_valid is ignored while s_ready=0, and the upstream vector is not
//    consumed. The block never drops a captured lane except on rst.
// TESTING (R=4, WY=16, WO=8, SHIFT=4)
//  1 Single vector [24,-24,40,-8] with s_last=1 and m_ready=1:
//    - m_data = 2,-1,3,0 on 4 consecutive cycles, starting 1 cycle after
//      capture.
//    - m_last only on beat 4; s_ready=0 during beats 1-3.
//  2 Saturation [3000,-3000,32767,-32768]:
//    - m_data = 127,-128,127,-128.
//    - 32767 must not wrap: the WY+1 adder gives 2048, which saturates to 127.
//  3 Backpressure: same vector as test 1, m_ready toggling 1,0,0,1,...
//    - m_data and m_last held while stalled; all 4 lanes appear in order.
//  4 Back-to-back: two vectors with s_valid held high and m_ready=1.
//    - 8 beats with no bubble; second capture on the cycle beat 4 transfers.
//    - m_last per each vector's s_last.
//  5 Reset mid-stream: rst=1 after beat 2.
//    - Next cycle: m_valid=0, m_data=0, s_ready=1.
//    - A new vector [16,...] then yields m_data=1 first.
//  6 SHIFT=0 variant: [100,-200,127,-129] -> m_data = 100,-128,127,-128.

Source files
------------

// File: rtl/acc_out_serializer.sv
// Captures one column of accumulator results and streams them out one lane per beat,
// requantized (round-half-up shift, signed saturation) onto an AXI-Stream master.
module acc_out_serializer #(
  parameter int R     = 4,
  parameter int WY    = 16,
  parameter int WO    = 8,
  parameter int SHIFT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [R*WY-1:0] s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [WO-1:0]   m_data,
  output logic            m_last
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic signed [WY:0] RND =
    (SHIFT > 0) ? ((WY+1)'(1) << RS) : '0;
  localparam logic signed [WY:0] QMAX =
    (WY+1)'((1 << (WO - 1)) - 1);
  localparam logic signed [WY:0] QMIN = ~QMAX;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [WY-1:0] lane_q [R];

  logic          last_lane;
  logic          cap;
  logic          beat;

  assign last_lane = (cnt_q == CW'(R - 1));
  assign m_valid   = (state_q == SEND);
  assign s_ready   = (state_q == IDLE) | (last_lane & m_ready);
  assign cap       = s_valid & s_ready;
  assign beat      = m_valid & m_ready;
  assign m_last    = m_valid & last_q & last_lane;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (cap) begin
      state_d = SEND;
      cnt_d   = '0;
      last_d  = s_last;
    end else if (beat) begin
      if (last_lane) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      for (int r = 0; r < R; r++) lane_q[r] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      if (cap) begin
        for (int r = 0; r < R; r++) begin
          lane_q[r] <= s_data[r*WY +: WY];
        end
      end
    end
  end

  // One extra bit of headroom keeps the rounding add from wrapping.
  logic signed [WY:0] t;
  logic signed [WY:0] q;

  always_comb begin
    t      = $signed({lane_q[cnt_q][WY-1], lane_q[cnt_q]}) + RND;
    q      = t >>> SHIFT;
    m_data = '0;
    if (m_valid) begin
      if (q > QMAX)      m_data = QMAX[WO-1:0];
      else if (q < QMIN) m_data = QMIN[WO-1:0];
      else               m_data = q[WO-1:0];
    end
  end

endmodule

// File: tb/tb_acc_out_serializer.sv
// Directed bench: per-cycle vectors checking handshake and requantized stream,
// with a SHIFT=4 instance and a SHIFT=0 instance sharing stimulus.
module tb_acc_out_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_last;
  logic        m_ready;

  logic        s_ready4, m_valid4, m_last4;
  logic [7:0]  m_data4;
  logic        s_ready0, m_valid0, m_last0;
  logic [7:0]  m_data0;

  int ntest = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  acc_out_serializer #(.R(4), .WY(16), .WO(8), .SHIFT(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready4),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .m_last(m_last4)
  );

  acc_out_serializer #(.R(4), .WY(16), .WO(8), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid0), .m_ready(m_ready),
    .m_data(m_data0), .m_last(m_last0)
  );

  typedef struct {
    logic        rst;
    logic        sv;
    logic [63:0] d;
    logic        sl;
    logic        mr;
    logic        emv;
    int          emd;
    logic        eml;
    logic        esr;
  } vec_t;

  function automatic logic [63:0] pk(int a, int b, int c, int d);
    logic [15:0] a16, b16, c16, d16;
    a16 = 16'(a); b16 = 16'(b); c16 = 16'(c); d16 = 16'(d);
    return {d16, c16, b16, a16};
  endfunction

  task automatic step(input logic r, input logic sv,
                      input logic [63:0] d, input logic sl,
                      input logic mr, input logic emv, input int emd,
                      input logic eml, input logic esr,
                      input bit sel, input string nm);
    logic [10:0] act, exp;
    @(negedge clk);
    rst = r; s_valid = sv; s_data = d; s_last = sl; m_ready = mr;
    #1;
    if (sel) act = {m_valid0, m_data0, m_last0, s_ready0};
    else     act = {m_valid4, m_data4, m_last4, s_ready4};
    exp = {emv, 8'(emd), eml, esr};
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got v=%0b d=%0d l=%0b rdy=%0b want v=%0b d=%0d l=%0b rdy=%0b",
               nm, act[10], $signed(act[9:2]), act[1], act[0],
               exp[10], $signed(exp[9:2]), exp[1], exp[0]);
    end
  endtask

  vec_t tbl [12];
  logic [63:0] v1, v2, v3, v5, v6;

  initial begin
    v1 = pk(24, -24, 40, -8);
    v2 = pk(3000, -3000, 32767, -32768);
    v3 = pk(16, 32, -16, -40);
    v5 = pk(16, 0, 0, 0);
    v6 = pk(100, -200, 127, -129);

    tbl[0]  = '{1'b0, 1'b1, v1, 1'b1, 1'b1, 1'b0,    0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, v1, 1'b1, 1'b1, 1'b1,    2, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, v1, 1'b1, 1'b1, 1'b1,   -1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, v1, 1'b1, 1'b1, 1'b1,    3, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, v1, 1'b1, 1'b1, 1'b1,    0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, v2, 1'b0, 1'b1, 1'b0,    0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, v2, 1'b0, 1'b1, 1'b1,  127, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, v2, 1'b0, 1'b1, 1'b1, -128, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, v2, 1'b0, 1'b1, 1'b1,  127, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, v2, 1'b0, 1'b1, 1'b1, -128, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, v2, 1'b0, 1'b1, 1'b0,    0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, v2, 1'b0, 1'b0, 1'b0,    0, 1'b0, 1'b1};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);

    step(0, 0, '0, 0, 1, 0, 0, 0, 1, 0, "reset4");
    step(0, 0, '0, 0, 1, 0, 0, 0, 1, 1, "reset0");

    // single vector and saturation
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].sv, tbl[i].d, tbl[i].sl, tbl[i].mr,
           tbl[i].emv, tbl[i].emd, tbl[i].eml, tbl[i].esr, 0,
           $sformatf("tbl%0d", i));
    end

    // backpressure, m_ready 1,0,0 repeating
    step(0, 1, v1, 1, 1, 0,  0, 0, 1, 0, "bp_cap");
    step(0, 0, v1, 1, 1, 1,  2, 0, 0, 0, "bp_c1");
    step(0, 0, v1, 1, 0, 1, -1, 0, 0, 0, "bp_c2");
    step(0, 0, v1, 1, 0, 1, -1, 0, 0, 0, "bp_c3");
    step(0, 0, v1, 1, 1, 1, -1, 0, 0, 0, "bp_c4");
    step(0, 0, v1, 1, 0, 1,  3, 0, 0, 0, "bp_c5");
    step(0, 0, v1, 1, 0, 1,  3, 0, 0, 0, "bp_c6");
    step(0, 0, v1, 1, 1, 1,  3, 0, 0, 0, "bp_c7");
    step(0, 0, v1, 1, 0, 1,  0, 1, 0, 0, "bp_c8");
    step(0, 0, v1, 1, 0, 1,  0, 1, 0, 0, "bp_c9");
    step(0, 0, v1, 1, 1, 1,  0, 1, 1, 0, "bp_c10");
    step(0, 0, v1, 1, 1, 0,  0, 0, 1, 0, "bp_idle");

    // back-to-back with s_valid held high
    step(0, 1, v1, 0, 1, 0,  0, 0, 1, 0, "b2b_cap");
    step(0, 1, v3, 1, 1, 1,  2, 0, 0, 0, "b2b_a1");
    step(0, 1, v3, 1, 1, 1, -1, 0, 0, 0, "b2b_a2");
    step(0, 1, v3, 1, 1, 1,  3, 0, 0, 0, "b2b_a3");
    step(0, 1, v3, 1, 1, 1,  0, 0, 1, 0, "b2b_a4");
    step(0, 0, v3, 1, 1, 1,  1, 0, 0, 0, "b2b_b1");
    step(0, 0, v3, 1, 1, 1,  2, 0, 0, 0, "b2b_b2");
    step(0, 0, v3, 1, 1, 1, -1, 0, 0, 0, "b2b_b3");
    step(0, 0, v3, 1, 1, 1, -2, 1, 1, 0, "b2b_b4");
    step(0, 0, v3, 1, 1, 0,  0, 0, 1, 0, "b2b_idle");

    // reset mid-stream
    step(0, 1, v1, 1, 1, 0,  0, 0, 1, 0, "rst_cap");
    step(0, 0, v1, 1, 1, 1,  2, 0, 0, 0, "rst_b1");
    step(0, 0, v1, 1, 1, 1, -1, 0, 0, 0, "rst_b2");
    step(1, 0, v1, 1, 1, 1,  3, 0, 0, 0, "rst_assert");
    step(0, 0, v1, 1, 1, 0,  0, 0, 1, 0, "rst_after");
    step(0, 1, v5, 0, 1, 0,  0, 0, 1, 0, "rst_newcap");
    step(0, 0, v5, 0, 1, 1,  1, 0, 0, 0, "rst_n1");
    step(0, 0, v5, 0, 1, 1,  0, 0, 0, 0, "rst_n2");
    step(0, 0, v5, 0, 1, 1,  0, 0, 0, 0, "rst_n3");
    step(0, 0, v5, 0, 1, 1,  0, 0, 1, 0, "rst_n4");
    step(0, 0, v5, 0, 1, 0,  0, 0, 1, 0, "rst_idle");

    // SHIFT=0 instance
    step(0, 1, v6, 1, 1, 0,    0, 0, 1, 1, "s0_cap");
    step(0, 0, v6, 1, 1, 1,  100, 0, 0, 1, "s0_b1");
    step(0, 0, v6, 1, 1, 1, -128, 0, 0, 1, "s0_b2");
    step(0, 0, v6, 1, 1, 1,  127, 0, 0, 1, "s0_b3");
    step(0, 0, v6, 1, 1, 1, -128, 1, 1, 1, "s0_b4");
    step(0, 0, v6, 1, 1, 0,    0, 0, 1, 1, "s0_idle");

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
